// File: rtl/fma16_result_q.sv
// Writeback queue for fma16 results: DEPTH-entry FIFO of {result, flags} with
// sticky IEEE exception flags and a saturating invalid-operation counter.
module fma16_result_q #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_result,
  input  logic [3:0]    in_flags,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_result,
  output logic [3:0]    out_flags,
  output logic [CW-1:0] count,
  output logic [3:0]    fflags,
  input  logic          fflags_clr,
  output logic [7:0]    nv_count
);

  localparam int PW     = $clog2(DEPTH);
  localparam int DATA_W = 16;
  localparam int FLAG_W = 4;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem_result [DEPTH];
  logic [FLAG_W-1:0] mem_flags  [DEPTH];
  logic              enq;
  logic              deq;
  logic              nv_inc;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    if (inc && (v != 8'hFF)) return v + 8'd1;
    return v;
  endfunction

  // Full/empty come from the occupancy count so pointers may simply wrap.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  assign nv_inc    = enq && in_flags[3];

  assign out_result = out_valid ? mem_result[rd_ptr] : '0;
  assign out_flags  = out_valid ? mem_flags[rd_ptr]  : '0;

  // Entry storage carries no reset; emptiness is masked at the output.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_result[wr_ptr] <= in_result;
      mem_flags[wr_ptr]  <= in_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fflags   <= '0;
      nv_count <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Accumulate after the clear so a same-cycle enqueue is not lost.
      fflags   <= (fflags_clr ? 4'h0 : fflags) | (enq ? in_flags : 4'h0);
      nv_count <= fflags_clr ? {7'd0, nv_inc} : sat_inc8(nv_count, nv_inc);
    end
  end

endmodule

// File: tb/tb_fma16_result_q.sv
// Directed bench for fma16_result_q: queue-based reference model compared on
// every falling edge, plus literal expectations at key points.
module tb_fma16_result_q;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_result = '0;
  logic [3:0]    in_flags = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   out_result;
  logic [3:0]    out_flags;
  logic [CW-1:0] count;
  logic [3:0]    fflags;
  logic          fflags_clr = 1'b0;
  logic [7:0]    nv_count;

  int total = 0;
  int bad   = 0;

  fma16_result_q #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .count(count), .fflags(fflags),
    .fflags_clr(fflags_clr), .nv_count(nv_count)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of {result, flags} plus sticky state.
  logic [19:0] mq[$];
  logic [3:0]  m_ff = '0;
  int          m_nv = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ff = '0;
      m_nv = 0;
    end else begin
      bit acc, take, nv;
      acc  = in_valid && (mq.size() != DEPTH);
      take = out_ready && (mq.size() != 0);
      nv   = acc && in_flags[3];
      if (take) void'(mq.pop_front());
      if (acc) mq.push_back({in_result, in_flags});
      m_ff = (fflags_clr ? 4'h0 : m_ff) | (acc ? in_flags : 4'h0);
      if (fflags_clr) m_nv = nv ? 1 : 0;
      else if (nv && m_nv < 255) m_nv = m_nv + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [19:0] head;
    head = (mq.size() != 0) ? mq[0] : 20'h0;
    chk("out_valid",  32'(out_valid),  32'(mq.size() != 0));
    chk("in_ready",   32'(in_ready),   32'(mq.size() != DEPTH));
    chk("count",      32'(count),      32'(mq.size()));
    chk("out_result", 32'(out_result), 32'(head[19:4]));
    chk("out_flags",  32'(out_flags),  32'(head[3:0]));
    chk("fflags",     32'(fflags),     32'(m_ff));
    chk("nv_count",   32'(nv_count),   32'(m_nv));
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] f,
                       input logic ordy, input logic clr);
    in_valid   = v;
    in_result  = r;
    in_flags   = f;
    out_ready  = ordy;
    fflags_clr = clr;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);

    // Two back-to-back enqueues, consumer stalled.
    drive(1, 16'h3C00, 4'h0, 0, 0); cyc();
    drive(1, 16'h7E00, 4'h8, 0, 0); cyc();
    chk("two_count", 32'(count), 32'd2);
    chk("two_head", 32'(out_result), 32'h3C00);
    chk("two_fflags", 32'(fflags), 32'h8);
    chk("two_nv", 32'(nv_count), 32'd1);

    // Fill to DEPTH, then offer while dequeuing: offer must be refused.
    drive(1, 16'h4000, 4'h1, 0, 0); cyc();
    drive(1, 16'h4200, 4'h0, 0, 0); cyc();
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1, 16'h1234, 4'h4, 1, 0); cyc();
    chk("full_deq_count", 32'(count), 32'd3);
    chk("full_deq_head", 32'(out_result), 32'h7E00);
    chk("full_deq_fflags", 32'(fflags), 32'h9);

    // Drain, including extra cycles of out_ready on an empty queue.
    drive(0, 16'h0, 4'h0, 1, 0);
    repeat (5) cyc();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_result", 32'(out_result), 32'h0);

    // Set fflags to 4'hA, then enqueue 4'h5 during a clear.
    drive(1, 16'h5555, 4'hA, 1, 1); cyc();
    chk("a_fflags", 32'(fflags), 32'hA);
    chk("a_nv", 32'(nv_count), 32'd1);
    drive(1, 16'h6666, 4'h5, 1, 1); cyc();
    chk("clr_fflags", 32'(fflags), 32'h5);
    chk("clr_nv", 32'(nv_count), 32'd0);
    drive(0, 16'h0, 4'h0, 1, 0); cyc();

    // Streaming: 20 enqueues with continuous dequeue.
    for (int i = 0; i < 20; i++) begin
      drive(1, 16'(16'hA000 + i), 4'(i), 1, 0);
      cyc();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_head", 32'(out_result), 32'(16'hA000 + i));
    end
    drive(0, 16'h0, 4'h0, 1, 0); cyc();

    // 300 NV enqueues, starting with a clear: counter saturates.
    for (int i = 0; i < 300; i++) begin
      drive(1, 16'(i), 4'h8, 1, (i == 0));
      cyc();
    end
    drive(0, 16'h0, 4'h0, 1, 0); cyc();
    chk("sat_nv", 32'(nv_count), 32'd255);
    chk("sat_fflags", 32'(fflags), 32'h8);

    // Three entries, then asynchronous reset mid-cycle.
    drive(1, 16'h1111, 4'h0, 0, 0); cyc();
    drive(1, 16'h2222, 4'h0, 0, 0); cyc();
    drive(1, 16'h3333, 4'h0, 0, 0); cyc();
    drive(0, 16'h0, 4'h0, 0, 0);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_nv", 32'(nv_count), 32'd0);
    cyc();
    rst_n = 1'b1;
    drive(1, 16'hBEEF, 4'h2, 0, 0); cyc();
    drive(0, 16'h0, 4'h0, 0, 0);
    chk("post_rst_head", 32'(out_result), 32'hBEEF);
    chk("post_rst_flags", 32'(out_flags), 32'h2);
    chk("post_rst_count", 32'(count), 32'd1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fma16_result_q.md
# fma16_result_q

Result/flag writeback queue placed directly downstream of the combinational half-precision FMA datapath (`fma16`). It accepts one `{result, flags}` pair per cycle under a valid/ready handshake and buffers pairs in a DEPTH-entry FIFO so a stalled consumer never drops an FMA result. It also accumulates IEEE exception flags into a sticky `fflags` register and counts invalid operations until software clears them.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a result this cycle.
- in_ready  out  1  queue can accept; equals (count != DEPTH).
- in_result  in  16  binary16 result from fma16.
- in_flags  in  4  {NV, OF, UF, NX} from fma16 (bit 3 invalid, 2 overflow, 1 underflow, 0 inexact).
- out_valid  out  1  head entry present; equals (count != 0).
- out_ready  in  1  consumer takes the head this cycle.
- out_result  out  16  head entry result; 16'h0000 when empty.
- out_flags  out  4  head entry flags; 4'h0 when empty.
- count  out  CW  current occupancy, 0..DEPTH.
- fflags  out  4  sticky OR of the flags of all accepted entries since the last clear.
- fflags_clr  in  1  synchronous clear of fflags and nv_count.
- nv_count  out  8  number of accepted entries with NV set, saturating at 255.

## Operation
- Enqueue occurs when in_valid && in_ready: {in_result, in_flags} are written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Dequeue occurs when out_valid && out_ready: rd_ptr increments modulo DEPTH.
- count_next = count + enq - deq. A simultaneous enqueue and dequeue leaves count unchanged.
- in_ready depends only on count, never on out_ready. When the queue is full, the producer stalls even if a dequeue happens in the same cycle.
- out_result and out_flags are read combinationally from storage at rd_ptr and masked to zero when count == 0. Storage itself is not reset.
- fflags_next = (fflags_clr ? 4'h0 : fflags) | (enq ? in_flags : 4'h0). Accumulation is applied on enqueue, not on dequeue, so flags from a same-cycle enqueue survive a clear.
- nv_count_next = fflags_clr ? (enq && in_flags[3]) : sat255(nv_count + (enq && in_flags[3])).
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. Full and empty are derived from count, not from pointer equality.

## Timing
- Reset values (asserted asynchronously, released synchronously to the design): count=0, wr_ptr=0, rd_ptr=0, fflags=0, nv_count=0. Consequently out_valid=0, in_ready=1, out_result=0, out_flags=0.
- Latency: an entry accepted at edge N is visible on out_valid/out_result after edge N. There is no same-cycle bypass from in_* to out_*.
- Throughput: one enqueue and one dequeue per cycle when 0 < count < DEPTH.
- fflags and nv_count reflect an enqueue at edge N after edge N.
- Reset mid-operation discards all entries immediately. out_valid falls asynchronously with rst_n.
- Boundaries:
  - enq when full: impossible, because in_ready=0.
  - deq when empty: ignored, because out_valid=0 and pointers hold.
  - out_ready with no entry: no effect.
  - nv_count at 255 plus a NV enqueue: stays 255.

## Test plan
- Reset, then enqueue 16'h3C00/4'h0 followed by 16'h7E00/4'h8 back-to-back with out_ready=0 -> count=2; out_result=16'h3C00; fflags=4'h8; nv_count=1.
- Fill DEPTH=4 entries with out_ready=0 -> in_ready=0 at count=4. Drive in_valid=1 and out_ready=1 for one cycle -> count=3, and the offered entry is not accepted.
- Steady stream of 20 enqueues with out_ready=1 every cycle -> outputs appear in order, one cycle behind inputs; count stays 1; pointers wrap correctly past index 3.
- Enqueue flags 4'h5 in the same cycle as fflags_clr=1 with fflags previously 4'hA -> fflags=4'h5; nv_count=0.
- 300 enqueues with in_flags=4'h8 -> nv_count saturates at 255; fflags=4'h8.
- Assert rst_n=0 mid-cycle with count=3 -> out_valid=0 and count=0 immediately. After release, the first new enqueue appears as head.
